fifo_param: RTL and testbench

- Parametrised synchronous FIFO. Successor to the fixed 8-bit push/pop FIFO.
- Generalises data width and depth, and adds a selectable first-word-fall-through (FWFT) read mode.
- Adds an occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Sits between producer and consumer blocks in the same clock domain.

---
 rtl/fifo_param.sv | 134 +++++++++++++
 tb/tb_fifo_param.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with a separate occupancy counter, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// choice of registered or first-word-fall-through read data.
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    // A threshold at or above DEPTH simply means "always almost empty".
    localparam logic [CW-1:0] AE_C    = (AE_LEVEL >= DEPTH) ? DEPTH_C : CW'(AE_LEVEL);

    // Reject configurations the pointer arithmetic and flag logic cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_param: DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL > DEPTH || AF_LEVEL < 0) begin : g_bad_af
        $error("fifo_param: AF_LEVEL must lie in 0..DEPTH");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push_ok, pop_ok;

    // Flags come straight from the registered occupancy.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new error event takes priority over a clear in the same cycle.
        if (clr_err)           ovf_d = 1'b0;
        if (push && !push_ok)  ovf_d = 1'b1;
        if (clr_err)           unf_d = 1'b0;
        if (pop && !pop_ok)    unf_d = 1'b1;
    end

    // Control state register; reset discards all stored words at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din;
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented as soon as it exists; zero while empty.
        always_comb begin
            dout = '0;
            if (!empty) dout = mem_q[rptr_q];
        end
    end else begin : g_reg
        logic [WIDTH-1:0] dout_q, dout_d;

        // Output register loads the head word only on an accepted pop.
        always_comb begin
            dout_d = dout_q;
            if (pop_ok) dout_d = mem_q[rptr_q];
        end

        // Registered read data, cleared by reset and held between pops.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) dout_q <= '0;
            else       dout_q <= dout_d;
        end

        assign dout = dout_q;
    end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a registered-read instance driven against a
// queue-based reference, plus a first-word-fall-through instance.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       push0 = 1'b0, pop0 = 1'b0, clr0 = 1'b0;
    logic [7:0] din0 = '0, dout0;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic [2:0] cnt0;

    logic       push1 = 1'b0, pop1 = 1'b0, clr1 = 1'b0;
    logic [7:0] din1 = '0, dout1;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [2:0] cnt1;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    int stepno = 0;

    logic [7:0] model[$];
    logic [7:0] m_dout = '0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_dut0 (
        .clk(clk), .reset(reset), .push(push0), .pop(pop0), .din(din0),
        .dout(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0),
        .clr_err(clr0)
    );

    fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_dut1 (
        .clk(clk), .reset(reset), .push(push1), .pop(pop1), .din(din1),
        .dout(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1),
        .clr_err(clr1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output of the registered-read instance against the reference.
    task automatic check_all0(input string ctx);
        int n;
        n = model.size();
        check($sformatf("%s dout", ctx),  32'(dout0), 32'(m_dout));
        check($sformatf("%s count", ctx), 32'(cnt0),  32'(n));
        check($sformatf("%s full", ctx),  32'(full0), 32'(n == 4));
        check($sformatf("%s empty", ctx), 32'(empty0), 32'(n == 0));
        check($sformatf("%s afull", ctx), 32'(af0),   32'(n >= 2));
        check($sformatf("%s aempty", ctx), 32'(ae0),  32'(n <= 2));
        check($sformatf("%s ovf", ctx),   32'(ovf0),  32'(m_ovf));
        check($sformatf("%s unf", ctx),   32'(unf0),  32'(m_unf));
    endtask

    // One clock of stimulus: the reference decides acceptance, queues pushed
    // words and pops the expected word for comparison after the edge.
    task automatic step0(input logic p, input logic q, input logic [7:0] d, input logic c);
        logic pop_ok, push_ok;
        pop_ok  = q && (model.size() != 0);
        push_ok = p && ((model.size() < 4) || pop_ok);
        push0 = p; pop0 = q; din0 = d; clr0 = c;
        if (pop_ok)  m_dout = model.pop_front();
        if (push_ok) model.push_back(d);
        if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (p && !push_ok) m_ovf = 1'b1;
        if (q && !pop_ok)  m_unf = 1'b1;
        @(posedge clk);
        #1;
        push0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0;
        stepno++;
        check_all0($sformatf("s%0d", stepno));
    endtask

    initial begin
        // Reset state of both instances.
        #3;
        check_all0("reset");
        check("reset dout1", 32'(dout1), 32'h0);
        check("reset empty1", 32'(empty1), 32'h1);
        #9;
        reset = 1'b0;

        // Basic ordering.
        step0(1'b1, 1'b0, 8'h01, 1'b0);
        step0(1'b1, 1'b0, 8'h02, 1'b0);
        step0(1'b1, 1'b0, 8'h03, 1'b0);
        for (int i = 0; i < 3; i++) step0(1'b0, 1'b1, 8'h00, 1'b0);

        // Fill past full, drain, then clear the error.
        for (int i = 0; i < 5; i++) step0(1'b1, 1'b0, 8'(8'h04 + i), 1'b0);
        for (int i = 0; i < 4; i++) step0(1'b0, 1'b1, 8'h00, 1'b0);
        step0(1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous push and pop while full.
        for (int i = 0; i < 4; i++) step0(1'b1, 1'b0, 8'(8'h04 + i), 1'b0);
        step0(1'b1, 1'b1, 8'h09, 1'b0);
        // Overflow set in the same cycle as clear: set wins.
        step0(1'b1, 1'b0, 8'hEE, 1'b1);
        for (int i = 0; i < 4; i++) step0(1'b0, 1'b1, 8'h00, 1'b0);

        // Simultaneous push and pop while empty.
        step0(1'b0, 1'b0, 8'h00, 1'b1);
        step0(1'b1, 1'b1, 8'h0A, 1'b0);
        step0(1'b0, 1'b1, 8'h00, 1'b0);
        // Rejected pop holds dout; underflow set wins over clear.
        step0(1'b0, 1'b1, 8'h00, 1'b1);
        step0(1'b0, 1'b0, 8'h00, 1'b1);

        // Alternating traffic across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            step0(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
            step0(1'b0, 1'b1, 8'h00, 1'b0);
        end

        // Asynchronous reset between edges with three words stored.
        step0(1'b1, 1'b0, 8'h31, 1'b0);
        step0(1'b1, 1'b0, 8'h32, 1'b0);
        step0(1'b1, 1'b0, 8'h33, 1'b0);
        #2;
        reset = 1'b1;
        model.delete();
        m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        check_all0("async");
        #2;
        reset = 1'b0;
        step0(1'b1, 1'b0, 8'h77, 1'b0);
        step0(1'b0, 1'b1, 8'h00, 1'b0);
        step0(1'b0, 1'b0, 8'h00, 1'b0);

        // First-word-fall-through instance.
        check("fwft idle empty", 32'(empty1), 32'h1);
        push1 = 1'b1; din1 = 8'h55;
        @(posedge clk); #1;
        push1 = 1'b0;
        check("fwft show", 32'(dout1), 32'h55);
        check("fwft cnt1", 32'(cnt1), 32'h1);
        @(posedge clk); #1;
        check("fwft hold", 32'(dout1), 32'h55);
        push1 = 1'b1; din1 = 8'h66;
        @(posedge clk); #1;
        push1 = 1'b0;
        check("fwft head", 32'(dout1), 32'h55);
        check("fwft cnt2", 32'(cnt1), 32'h2);
        pop1 = 1'b1;
        @(posedge clk); #1;
        check("fwft next", 32'(dout1), 32'h66);
        @(posedge clk); #1;
        pop1 = 1'b0;
        check("fwft drained dout", 32'(dout1), 32'h0);
        check("fwft drained empty", 32'(empty1), 32'h1);
        check("fwft no unf", 32'(unf1), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
